// File: rtl/mul_pkg.sv
// Shared definitions for the sequential approximate 4x4 multiplier.
package mul_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned RES_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift applied to each partial product, indexed by step: {0, 2, 2, 4}.
   function automatic logic [2:0] step_shift(input logic [1:0] step);
      logic [2:0] sh;
      unique case (step)
         2'd0:    sh = 3'd0;
         2'd1:    sh = 3'd2;
         2'd2:    sh = 3'd2;
         default: sh = 3'd4;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mul2a.sv
// 2x2 approximate multiplier: exact except 3x3, which yields 7.
module mul2a (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   // 3x3 is the only product needing a fourth bit; clamping it to 7 keeps the output 3 bits wide.
   always_comb begin
      if (a == 2'd3 && b == 2'd3) begin
         p = 4'd7;
      end else begin
         p = {2'b00, a} * {2'b00, b};
      end
   end

endmodule

// File: rtl/mul4_seq_ctrl.sv
// Sequential 4x4 approximate multiplier: one shared mul2a, one partial product per clock.
module mul4_seq_ctrl
   import mul_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] result,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_t           state;
   logic [1:0]       step;
   logic [RES_W-1:0] acc;
   logic [OP_W-1:0]  a_q;
   logic [OP_W-1:0]  b_q;

   logic [1:0]       mul_a;
   logic [1:0]       mul_b;
   logic [3:0]       pp;
   logic [RES_W-1:0] pp_shifted;

   // Step bit 1 picks the high digit of a, step bit 0 the high digit of b.
   always_comb begin
      mul_a      = step[1] ? a_q[3:2] : a_q[1:0];
      mul_b      = step[0] ? b_q[3:2] : b_q[1:0];
      pp_shifted = {4'b0000, pp} << step_shift(step);
   end

   mul2a u_mul2a (
      .a (mul_a),
      .b (mul_b),
      .p (pp)
   );

   // Handshake and status outputs; in_ready follows out_ready combinationally in DONE.
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      result    = acc;
   end

   // FSM, operand latches, accumulator and saturating result counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         step     <= 2'd0;
         acc      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  acc   <= '0;
                  step  <= 2'd0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc  <= acc + pp_shifted;
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  if (op_count != '1) begin
                     op_count <= op_count + CNT_W'(1);
                  end
                  // Back-to-back accept skips the IDLE bubble.
                  if (in_valid) begin
                     a_q   <= a;
                     b_q   <= b;
                     acc   <= '0;
                     step  <= 2'd0;
                     state <= CALC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
